pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Top-level game sequencer for the ping-pong design. It tracks scores, runs serve and point-pause delays off the 1 ms tick, and drives the 2-bit game_state code that selects the pixel colour source in the renderer. It also gates ball/paddle motion and requests ball re-centring between points.

Parameters:
WIN_SCORE, 5, points needed to win (1..15).
SERVE_MS, 1000, delay in clk_1ms ticks from serve start to ball release.
POINT_MS, 500, pause in clk_1ms ticks after a point before the next serve or win screen.

Ports:
clk  in  1  system pixel clock.
reset  in  1  synchronous, active-high reset.
clk_1ms  in  1  one-clk-wide pulse, once per millisecond.
start_btn  in  1  debounced start level; the block detects the rising edge internally.
miss_left  in  1  one-cycle pulse: ball passed paddle1, so player 2 scores.
miss_right  in  1  one-cycle pulse: ball passed paddle2, so player 1 scores.
game_state  out  2  00 idle/start screen, 01 playing, 10 player1 wins, 11 player2 wins.
motion_en  out  1  high only in PLAY; ball/paddle movers advance only when it is high.
ball_reset  out  1  one-cycle pulse requesting the ball to re-centre.
serve_dir  out  1  0 = serve toward player1 (left), 1 = toward player2 (right).
score1  out  4  player1 score.
score2  out  4  player2 score.

Behaviour:
- Clocking and reset:
  - All registers update on posedge clk.
  - reset is synchronous, active-high, and has priority over all other inputs.
  - Reset values: state IDLE, game_state 00, motion_en 0, ball_reset 0, serve_dir 0, score1 0, score2 0, ms counter 0, start edge register 0.
  - Reset mid-game returns to IDLE and clears scores on the same edge.
- start_rise = start_btn & ~start_btn_q, where start_btn_q is a one-cycle delayed copy.
- Internal states and their game_state code: IDLE (00), SERVE (01), PLAY (01), POINT (01), WIN1 (10), WIN2 (11).
- IDLE:
  - On start_rise: clear scores, set serve_dir = 0, pulse ball_reset, go to SERVE, clear the ms counter.
- SERVE:
  - The ms counter increments on each clk_1ms.
  - When the counter reaches SERVE_MS-1 and a clk_1ms pulse arrives: go to PLAY and clear the counter.
- PLAY:
  - motion_en = 1, registered, so it is asserted the cycle after entering PLAY.
  - miss_right: score1 += 1, serve_dir <= 1 (serve goes away from the scorer toward the loser), go to POINT.
  - miss_left: score2 += 1, serve_dir <= 0, go to POINT.
  - If both misses arrive in the same cycle: miss_right wins and miss_left is ignored.
  - Misses outside PLAY are ignored.
- POINT:
  - Wait POINT_MS ticks, counted like SERVE.
  - On expiry:
    - score1 == WIN_SCORE → WIN1.
    - else score2 == WIN_SCORE → WIN2.
    - else pulse ball_reset and go to SERVE.
- WIN1/WIN2:
  - Hold until start_rise, then behave exactly as the IDLE start: scores 0, ball_reset pulse, SERVE.
- ball_reset:
  - Exactly one cycle wide.
  - Registered, so it is high the cycle after the transition into SERVE.
- Scores:
  - 4-bit saturating at WIN_SCORE; they never exceed it.
  - Score outputs are registered.
- ms counter:
  - 10 bits minimum; width = clog2(max(SERVE_MS, POINT_MS)).
  - Cleared on every state entry.
  - clk_1ms arriving in the same cycle as a state entry is not counted.
- Latency:
  - game_state changes the cycle after the triggering event.
  - The renderer adds one more register stage.

Decomposition:
- Shared package pong_pkg holds:
  - game_state codes GS_IDLE=2'b00, GS_PLAY=2'b01, GS_P1WIN=2'b10, GS_P2WIN=2'b11; the renderer must use the same constants.
  - The internal state enum.
  - The default WIN_SCORE value.
- One natural sub-module: ms_timer.
  - Loadable terminal count, clear input, tick input, one-cycle done output.
  - Reused for SERVE and POINT.

Test Plan:
1. Reset asserted for 3 clk mid-PLAY with score1=3 → next cycle game_state=00, score1=score2=0, motion_en=0.
2. start_btn held high for 100 clk from IDLE → exactly one ball_reset pulse; game_state=01; motion_en rises after exactly SERVE_MS clk_1ms ticks (use SERVE_MS=4).
3. In PLAY, pulse miss_right → score1=1, serve_dir=1, motion_en=0 next cycle; after POINT_MS ticks a ball_reset pulse occurs and the block is in SERVE.
4. miss_left and miss_right in the same cycle → score1 +1, score2 unchanged.
5. WIN_SCORE=2: two miss_left points → after POINT delay game_state=11, score2=2; further miss pulses cause no change; start_rise → scores 0, game_state=01.
6. miss_left pulse during SERVE or IDLE → no score change, no state change.

Source files
------------

// File: rtl/pong_game_ctrl_pkg.sv
// Shared constants and types for the ping-pong game controller and renderer.
// The game_state codes here select the renderer's pixel colour source.
package pong_pkg;

  localparam logic [1:0] GS_IDLE  = 2'b00;
  localparam logic [1:0] GS_PLAY  = 2'b01;
  localparam logic [1:0] GS_P1WIN = 2'b10;
  localparam logic [1:0] GS_P2WIN = 2'b11;

  localparam int unsigned WinScoreDefault = 5;

  typedef enum logic [2:0] {
    StIdle,
    StServe,
    StPlay,
    StPoint,
    StWin1,
    StWin2
  } pong_state_e;

  // SERVE, PLAY and POINT all present as "playing" to the renderer.
  function automatic logic [1:0] state_to_gs(pong_state_e st);
    logic [1:0] gs;
    case (st)
      StServe, StPlay, StPoint: gs = GS_PLAY;
      StWin1:                   gs = GS_P1WIN;
      StWin2:                   gs = GS_P2WIN;
      default:                  gs = GS_IDLE;
    endcase
    return gs;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Game-controller signal bundle: player/timing events in, sequencing and scores out.
// master is the controller; slave is the surrounding game logic.
interface pong_game_ctrl_if;

  logic       clk_1ms;
  logic       start_btn;
  logic       miss_left;
  logic       miss_right;
  logic [1:0] game_state;
  logic       motion_en;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;

  modport master (
    input  clk_1ms,
    input  start_btn,
    input  miss_left,
    input  miss_right,
    output game_state,
    output motion_en,
    output ball_reset,
    output serve_dir,
    output score1,
    output score2
  );

  modport slave (
    output clk_1ms,
    output start_btn,
    output miss_left,
    output miss_right,
    input  game_state,
    input  motion_en,
    input  ball_reset,
    input  serve_dir,
    input  score1,
    input  score2
  );

endinterface

// File: rtl/pong_game_ctrl_ms_timer.sv
// Millisecond tick counter with loadable terminal count; done_o fires on the tick
// that completes term_i ticks since the last clear.
module ms_timer #(
  parameter int unsigned CntW = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            tick_i,
  input  logic [CntW-1:0] term_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_term;

  // done_o deliberately ignores clear_i: the owner derives clear_i from done_o.
  assign at_term = (cnt_q == (term_i - 1'b1));
  assign done_o  = tick_i & at_term;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = at_term ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Ping-pong game sequencer: scores, serve/point delays off the 1 ms tick, and the
// game_state code, motion gate and ball re-centre request for the rest of the game.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE = WinScoreDefault,
  parameter int unsigned SERVE_MS  = 1000,
  parameter int unsigned POINT_MS  = 500
) (
  input logic              clk,
  input logic              reset,
  pong_game_ctrl_if.master bus
);

  localparam int unsigned MaxMs   = (SERVE_MS > POINT_MS) ? SERVE_MS : POINT_MS;
  localparam int unsigned MsBits  = $clog2(MaxMs + 1);
  localparam int unsigned CntW    = (MsBits > 10) ? MsBits : 10;
  localparam logic [3:0]  WinScore = 4'(WIN_SCORE);
  localparam logic [CntW-1:0] ServeTerm = CntW'(SERVE_MS);
  localparam logic [CntW-1:0] PointTerm = CntW'(POINT_MS);

  pong_state_e state_q, state_d;
  logic        start_q;
  logic        start_rise;
  logic [3:0]  score1_q, score1_d;
  logic [3:0]  score2_q, score2_d;
  logic        dir_q, dir_d;
  logic        ball_reset_q, ball_reset_d;
  logic        motion_q, motion_d;

  logic            tmr_clear;
  logic            tmr_done;
  logic [CntW-1:0] tmr_term;

  assign start_rise = bus.start_btn & ~start_q;

  // Hold the counter cleared outside the timed states and on every state change,
  // so a tick coinciding with a state entry is never counted toward the new state.
  assign tmr_clear = (state_d != state_q) || !(state_q inside {StServe, StPoint});
  assign tmr_term  = (state_q == StPoint) ? PointTerm : ServeTerm;

  ms_timer #(
    .CntW (CntW)
  ) u_ms_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (tmr_clear),
    .tick_i  (bus.clk_1ms),
    .term_i  (tmr_term),
    .done_o  (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    dir_d        = dir_q;
    ball_reset_d = 1'b0;
    unique case (state_q)
      StIdle, StWin1, StWin2: begin
        if (start_rise) begin
          score1_d     = '0;
          score2_d     = '0;
          dir_d        = 1'b0;
          ball_reset_d = 1'b1;
          state_d      = StServe;
        end
      end
      StServe: begin
        if (tmr_done) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        // miss_right takes priority when both misses land together.
        if (bus.miss_right) begin
          if (score1_q < WinScore) score1_d = score1_q + 4'd1;
          dir_d   = 1'b1;
          state_d = StPoint;
        end else if (bus.miss_left) begin
          if (score2_q < WinScore) score2_d = score2_q + 4'd1;
          dir_d   = 1'b0;
          state_d = StPoint;
        end
      end
      StPoint: begin
        if (tmr_done) begin
          if (score1_q == WinScore) begin
            state_d = StWin1;
          end else if (score2_q == WinScore) begin
            state_d = StWin2;
          end else begin
            ball_reset_d = 1'b1;
            state_d      = StServe;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    motion_d = (state_d == StPlay);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      score1_q     <= '0;
      score2_q     <= '0;
      dir_q        <= 1'b0;
      ball_reset_q <= 1'b0;
      motion_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= bus.start_btn;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      dir_q        <= dir_d;
      ball_reset_q <= ball_reset_d;
      motion_q     <= motion_d;
    end
  end

  assign bus.game_state = state_to_gs(state_q);
  assign bus.motion_en  = motion_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.serve_dir  = dir_q;
  assign bus.score1     = score1_q;
  assign bus.score2     = score2_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized bench for pong_game_ctrl against a countdown-based game model.
module tb_pong_game_ctrl;

  localparam int unsigned Win   = 2;
  localparam int unsigned Serve = 4;
  localparam int unsigned Point = 3;

  // Model phases of a game, independent of the design's state encoding.
  localparam int PhIdle  = 0;
  localparam int PhServe = 1;
  localparam int PhPlay  = 2;
  localparam int PhPoint = 3;
  localparam int PhWin1  = 4;
  localparam int PhWin2  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .WIN_SCORE (Win),
    .SERVE_MS  (Serve),
    .POINT_MS  (Point)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_phase;
  int m_left;
  int m_s1;
  int m_s2;
  bit m_dir;
  bit m_br;
  bit m_prev_start;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int exp_gs(input int ph);
    case (ph)
      PhServe, PhPlay, PhPoint: return 1;
      PhWin1:                   return 2;
      PhWin2:                   return 3;
      default:                  return 0;
    endcase
  endfunction

  task automatic new_game();
    m_s1    = 0;
    m_s2    = 0;
    m_dir   = 1'b0;
    m_br    = 1'b1;
    m_phase = PhServe;
    m_left  = Serve;
  endtask

  // Advance the model by one clock edge given the inputs present at that edge.
  task automatic model_step(input bit rst, input bit st, input bit tk, input bit ml,
                            input bit mr);
    bit rise;
    rise = st && !m_prev_start;
    m_prev_start = st;
    m_br = 1'b0;
    if (rst) begin
      m_phase = PhIdle;
      m_s1 = 0;
      m_s2 = 0;
      m_dir = 1'b0;
      m_left = 0;
      m_prev_start = 1'b0;
    end else begin
      case (m_phase)
        PhIdle, PhWin1, PhWin2: if (rise) new_game();
        PhServe: if (tk) begin
          m_left--;
          if (m_left == 0) m_phase = PhPlay;
        end
        PhPlay: begin
          if (mr) begin
            m_s1 = (m_s1 + 1 > Win) ? Win : m_s1 + 1;
            m_dir = 1'b1;
            m_phase = PhPoint;
            m_left = Point;
          end else if (ml) begin
            m_s2 = (m_s2 + 1 > Win) ? Win : m_s2 + 1;
            m_dir = 1'b0;
            m_phase = PhPoint;
            m_left = Point;
          end
        end
        PhPoint: if (tk) begin
          m_left--;
          if (m_left == 0) begin
            if (m_s1 == Win) m_phase = PhWin1;
            else if (m_s2 == Win) m_phase = PhWin2;
            else begin
              m_br = 1'b1;
              m_phase = PhServe;
              m_left = Serve;
            end
          end
        end
        default: m_phase = PhIdle;
      endcase
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit tk, input bit ml, input bit mr);
    @(negedge clk);
    reset          = rst;
    bus.start_btn  = st;
    bus.clk_1ms    = tk;
    bus.miss_left  = ml;
    bus.miss_right = mr;
    @(posedge clk);
    model_step(rst, st, tk, ml, mr);
    #1;
    check_eq("game_state", 16'(bus.game_state), 16'(exp_gs(m_phase)));
    check_eq("motion_en", 16'(bus.motion_en), 16'(m_phase == PhPlay));
    check_eq("ball_reset", 16'(bus.ball_reset), 16'(m_br));
    check_eq("serve_dir", 16'(bus.serve_dir), 16'(m_dir));
    check_eq("score1", 16'(bus.score1), 16'(m_s1));
    check_eq("score2", 16'(bus.score2), 16'(m_s2));
  endtask

  initial begin
    bit st;
    bus.start_btn  = 1'b0;
    bus.clk_1ms    = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    m_phase = PhIdle;
    m_left = 0;
    m_s1 = 0;
    m_s2 = 0;
    m_dir = 1'b0;
    m_br = 1'b0;
    m_prev_start = 1'b0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start held high: one ball_reset pulse, then PLAY after Serve ticks.
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, (i % 3) == 0, 1'b0, 1'b0);
    // Simultaneous misses in PLAY, then a miss during POINT.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, (i % 2) == 0, 1'b1, 1'b0);

    // Busy random play: frequent misses and ticks, occasional resets.
    st = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) st = ~st;
      cycle($urandom_range(0, 399) == 0, st, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    // Longer rallies: rare misses so PLAY persists, mid-game resets still possible.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) st = ~st;
      cycle($urandom_range(0, 499) == 0, st, $urandom_range(0, 1) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
